wb_stage: RTL and testbench

- MEM/WB pipeline register and writeback stage of the pipelined LC-3b core.
- Captures the MEM-stage result at posedge and selects the writeback word (ALU, memory word, memory byte, or PC+2).
- Drives the register file write port, which commits on negedge within the same cycle.
- Also holds the architectural NZP condition-code register, a forwarding tap, and a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_gencc.sv | 9 +
 rtl/wb_stage.sv | 66 ++++++
 tb/tb_wb_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: LC-3b word/register types, writeback select, NZP codes and WB entry record
package wb_stage_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0] lc3b_reg;
  typedef logic [2:0] lc3b_nzp;
  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_MEMW = 2'b01,
    WBSEL_MEMB = 2'b10,
    WBSEL_PC   = 2'b11
  } lc3b_wbsel;
  localparam lc3b_nzp NZP_RESET = 3'b010;
  typedef struct packed {
    logic valid;
    logic ld_regfile;
    logic ld_cc;
    lc3b_reg dest;
    lc3b_wbsel wbsel;
    lc3b_word alu_out;
    lc3b_word rdata;
    logic byte_hi;
    lc3b_word pc_plus2;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_gencc.sv
// gencc: word -> one-hot NZP (n=bit15 set, z=zero, p=otherwise); ports word in, nzp out
module gencc
  import wb_stage_pkg::*;
(
  input  logic [15:0] word,
  output logic [2:0]  nzp
);
  assign nzp = word[15] ? 3'b100 : (word == 16'h0000) ? 3'b010 : 3'b001;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register + writeback mux, regfile write port, forwarding tap, NZP register, retired counter
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_ld_regfile,
  input  logic                 mem_ld_cc,
  input  logic [2:0]           mem_dest,
  input  logic [1:0]           mem_wbsel,
  input  logic [15:0]          mem_alu_out,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_byte_hi,
  input  logic [15:0]          mem_pc_plus2,
  output logic                 regfile_load,
  output logic [2:0]           regfile_dest,
  output logic [15:0]          regfile_in,
  output logic                 wb_fwd_valid,
  output logic [2:0]           wb_fwd_dest,
  output logic [15:0]          wb_fwd_data,
  output logic [2:0]           cc_out,
  output logic [CNT_WIDTH-1:0] retired
);
  wb_entry_t wb, nxt;
  lc3b_nzp cc, nzp;
  lc3b_word wdata;
  logic [CNT_WIDTH-1:0] cnt;
  always_comb begin
    nxt = '{valid: mem_valid & ~flush, ld_regfile: mem_ld_regfile, ld_cc: mem_ld_cc,
            dest: mem_dest, wbsel: lc3b_wbsel'(mem_wbsel), alu_out: mem_alu_out,
            rdata: mem_rdata, byte_hi: mem_byte_hi, pc_plus2: mem_pc_plus2};
    wdata = (wb.wbsel == WBSEL_ALU)  ? wb.alu_out :
            (wb.wbsel == WBSEL_MEMW) ? wb.rdata :
            (wb.wbsel == WBSEL_MEMB) ? {8'h00, wb.byte_hi ? wb.rdata[15:8] : wb.rdata[7:0]} :
                                       wb.pc_plus2;
  end
  gencc u_gencc (
    .word(wdata),
    .nzp (nzp)
  );
  // A stalled entry stays in WB but retires (and sets NZP) only on the release edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb  <= '0;
      cc  <= NZP_RESET;
      cnt <= '0;
    end else if (!stall) begin
      wb <= nxt;
      if (wb.valid) cnt <= cnt + CNT_WIDTH'(1);
      if (wb.valid && wb.ld_cc) cc <= nzp;
    end
  end
  assign regfile_load = wb.valid & wb.ld_regfile;
  assign regfile_dest = wb.dest;
  assign regfile_in   = wdata;
  assign wb_fwd_valid = regfile_load;
  assign wb_fwd_dest  = regfile_dest;
  assign wb_fwd_data  = regfile_in;
  assign cc_out       = cc;
  assign retired      = cnt;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
  logic clk = 0, reset, stall, flush;
  logic mem_valid, mem_ld_regfile, mem_ld_cc, mem_byte_hi;
  logic [2:0] mem_dest;
  logic [1:0] mem_wbsel;
  logic [15:0] mem_alu_out, mem_rdata, mem_pc_plus2;
  logic regfile_load, wb_fwd_valid;
  logic [2:0] regfile_dest, wb_fwd_dest, cc_out;
  logic [15:0] regfile_in, wb_fwd_data;
  logic [3:0] retired;
  int checks = 0, failures = 0;
  wb_stage #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_ld_regfile(mem_ld_regfile), .mem_ld_cc(mem_ld_cc),
    .mem_dest(mem_dest), .mem_wbsel(mem_wbsel), .mem_alu_out(mem_alu_out),
    .mem_rdata(mem_rdata), .mem_byte_hi(mem_byte_hi), .mem_pc_plus2(mem_pc_plus2),
    .regfile_load(regfile_load), .regfile_dest(regfile_dest), .regfile_in(regfile_in),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data),
    .cc_out(cc_out), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic lr, input logic lc, input logic [2:0] d,
                       input logic [1:0] s, input logic [15:0] a, input logic [15:0] r,
                       input logic bh, input logic [15:0] p);
    mem_valid = v; mem_ld_regfile = lr; mem_ld_cc = lc; mem_dest = d; mem_wbsel = s;
    mem_alu_out = a; mem_rdata = r; mem_byte_hi = bh; mem_pc_plus2 = p;
  endtask
  task automatic wbchk(input string tag, input logic ld, input logic [2:0] d, input logic [15:0] w);
    chk({tag, "_load"}, 16'(regfile_load), 16'(ld));
    chk({tag, "_fwdv"}, 16'(wb_fwd_valid), 16'(ld));
    if (ld) begin
      chk({tag, "_dest"}, 16'(regfile_dest), 16'(d));
      chk({tag, "_in"}, regfile_in, w);
      chk({tag, "_fwdd"}, 16'(wb_fwd_dest), 16'(d));
      chk({tag, "_fwdw"}, wb_fwd_data, w);
    end
  endtask
  task automatic stchk(input string tag, input logic [2:0] cc, input logic [3:0] n);
    chk({tag, "_cc"}, 16'(cc_out), 16'(cc));
    chk({tag, "_ret"}, 16'(retired), 16'(n));
  endtask
  initial begin
    reset = 1; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    reset = 0;
    tick; tick;
    wbchk("idle", 0, 0, 0);
    stchk("idle", 3'b010, 0);
    drive(1, 1, 1, 3, 2'b00, 16'h8001, 0, 0, 0);
    tick;
    wbchk("add", 1, 3, 16'h8001);
    stchk("add_pre", 3'b010, 0);
    drive(1, 1, 1, 2, 2'b10, 0, 16'hA55A, 1, 0);
    tick;
    stchk("add_post", 3'b100, 1);
    wbchk("ldb_hi", 1, 2, 16'h00A5);
    drive(1, 1, 1, 2, 2'b10, 0, 16'hA55A, 0, 0);
    tick;
    stchk("ldb_hi_post", 3'b001, 2);
    wbchk("ldb_lo", 1, 2, 16'h005A);
    drive(1, 1, 0, 7, 2'b11, 16'hFFFF, 0, 0, 16'h3002);
    tick;
    stchk("ldb_lo_post", 3'b001, 3);
    wbchk("jsr", 1, 7, 16'h3002);
    drive(1, 1, 1, 1, 2'b00, 16'h0000, 0, 0, 0);
    tick;
    stchk("jsr_post", 3'b001, 4);
    wbchk("zero", 1, 1, 16'h0000);
    stall = 1;
    drive(1, 1, 1, 5, 2'b01, 16'h1234, 16'h8888, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      wbchk("stall", 1, 1, 16'h0000);
      stchk("stall", 3'b001, 4);
    end
    stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    stchk("release", 3'b010, 5);
    wbchk("bubble", 0, 0, 0);
    drive(1, 1, 1, 6, 2'b00, 16'h5555, 0, 0, 0);
    flush = 1;
    tick;
    wbchk("flush", 0, 0, 0);
    stchk("flush", 3'b010, 5);
    tick;
    stchk("flush2", 3'b010, 5);
    flush = 0;
    drive(1, 1, 0, 4, 2'b00, 16'h7777, 0, 0, 0);
    tick;
    wbchk("pre_sf", 1, 4, 16'h7777);
    stall = 1; flush = 1;
    drive(1, 1, 1, 6, 2'b00, 16'h8000, 0, 0, 0);
    tick;
    wbchk("stall_flush", 1, 4, 16'h7777);
    stchk("stall_flush", 3'b010, 5);
    stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    stchk("sf_release", 3'b010, 6);
    wbchk("sf_release", 0, 0, 0);
    drive(1, 1, 1, 2, 2'b00, 16'h8000, 0, 0, 0);
    tick;
    wbchk("pre_rst", 1, 2, 16'h8000);
    stall = 1; reset = 1;
    tick;
    stall = 0; reset = 0;
    wbchk("rst_stall", 0, 0, 0);
    stchk("rst_stall", 3'b010, 0);
    drive(0, 1, 1, 3, 2'b00, 16'h8000, 0, 0, 0);
    tick;
    wbchk("invalid", 0, 0, 0);
    tick;
    stchk("invalid", 3'b010, 0);
    drive(1, 1, 0, 1, 2'b00, 16'h0042, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick;
    stchk("wrap_pre", 3'b010, 15);
    tick;
    stchk("wrap", 3'b010, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    stchk("wrap_post", 3'b010, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
